// File: rtl/rx_derandomizer.sv
// Byte-stream derandomizer for the OFDM RX chain: XORs each accepted byte with the 802.16 PRBS (1+x^14+x^15),
// reseeded per burst, behind a 2-entry output buffer. Define RX_DERAND_STATS_EN to add the BYTE_CNT_O counter.
module rx_derandomizer #(
  parameter logic [14:0] SEED = 15'b100101010000000,
  parameter int          DW   = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I
`ifdef RX_DERAND_STATS_EN
  ,output logic [15:0]  BYTE_CNT_O
`endif
);

  // Handshake: a byte moves upstream on CYC_I & STB_I & WE_I & ACK_O at a rising edge, and
  // downstream on STB_O & ACK_I at a rising edge. ACK_O is a register, never a function of ACK_I.
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [1:0]    count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [14:0]   prbs_q, prbs_d;
  logic          new_burst_q, new_burst_d;
  logic          ack_q;
  logic          acc, pop;
  logic [14:0]   prbs_r;
  logic          prbs_fb;
  logic [DW-1:0] derand_byte;

  assign acc = CYC_I & STB_I & WE_I & ack_q;
  assign pop = (count_q != 2'd0) & ACK_I;

  // Eight LFSR steps per byte, MSB first; the first byte of a burst starts from SEED.
  always_comb begin
    prbs_r      = new_burst_q ? SEED : prbs_q;
    prbs_fb     = 1'b0;
    derand_byte = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      prbs_fb        = prbs_r[14] ^ prbs_r[13];
      derand_byte[i] = DAT_I[i] ^ prbs_fb;
      prbs_r         = {prbs_r[13:0], prbs_fb};
    end
    prbs_d      = acc ? prbs_r : prbs_q;
    new_burst_d = ~CYC_I | (new_burst_q & ~acc);
  end

  // head_q is the FIFO front and doubles as DAT_O, so it keeps the last byte when empty.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({acc, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = derand_byte;
        else                 tail_d = derand_byte;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = derand_byte;
        end else begin
          head_d = tail_q;
          tail_d = derand_byte;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = BUSY;
      BUSY:    if (!CYC_I) state_d = DRAIN;
      DRAIN: begin
        if (acc)                   state_d = BUSY;
        else if (count_q == 2'd0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      prbs_q      <= SEED;
      new_burst_q <= 1'b1;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      prbs_q      <= prbs_d;
      new_burst_q <= new_burst_d;
      ack_q       <= (count_d != 2'd2);
    end
  end

  assign ACK_O = ack_q;
  assign DAT_O = head_q;
  assign STB_O = (count_q != 2'd0);
  assign WE_O  = STB_O;
  assign CYC_O = (state_q != IDLE);

`ifdef RX_DERAND_STATS_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (state_q == IDLE && acc)              byte_cnt_d = 16'd0;
    else if (pop && byte_cnt_q != 16'hFFFF)  byte_cnt_d = byte_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) byte_cnt_q <= 16'd0;
    else       byte_cnt_q <= byte_cnt_d;
  end

  assign BYTE_CNT_O = byte_cnt_q;
`endif

endmodule

// File: tb/tb_rx_derandomizer.sv
// Scoreboard bench for rx_derandomizer: a driver pushes expected bytes on accept, a forked monitor pops on every output transfer.
module tb_rx_derandomizer;
  localparam logic [14:0] SEED = 15'b100101010000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dat_i;
  logic       cyc_i, stb_i, we_i, ack_i;
  logic       ack_o, cyc_o, stb_o, we_o;
  logic [7:0] dat_o;
`ifdef RX_DERAND_STATS_EN
  logic [15:0] byte_cnt_o;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [14:0] m_r;
  logic        m_new;

  rx_derandomizer dut (
    .CLK_I(clk), .RST_I(rst), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i),
    .ACK_O(ack_o), .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ACK_I(ack_i)
`ifdef RX_DERAND_STATS_EN
    , .BYTE_CNT_O(byte_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Keystream model: returns {next_register, key_byte}.
  function automatic logic [22:0] prbs8(input logic [14:0] r_in);
    logic [14:0] r;
    logic [7:0]  k;
    logic        fb;
    r = r_in;
    k = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      fb   = r[14] ^ r[13];
      k[i] = fb;
      r    = {r[13:0], fb};
    end
    return {r, k};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // mode 0: expect d^key; mode 1: expect given; mode 2: drive d^key (model randomizer), expect d.
  task automatic send(input logic [7:0] d, input int mode, input logic [7:0] given);
    logic [22:0] nx;
    logic [7:0]  key;
    bit          done;
    nx    = prbs8(m_new ? SEED : m_r);
    key   = nx[7:0];
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b1;
    dat_i = (mode == 2) ? (d ^ key) : d;
    done  = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (ack_o) begin
        done = 1'b1;
        exp_q.push_back((mode == 0) ? (d ^ key) : ((mode == 1) ? given : d));
        m_r   = nx[22:8];
        m_new = 1'b0;
        @(posedge clk); #1;
      end
    end
    stb_i = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=ack_o_low exp=ack_o_high");
    end
  endtask

  task automatic end_burst();
    cyc_i = 1'b0;
    stb_i = 1'b0;
    m_new = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !stb_o) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && stb_o && ack_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dat_o_unexpected got=%0h exp=none", dat_o);
        end else begin
          check("dat_o", 32'(dat_o), 32'(exp_q.pop_front()));
        end
        check("we_o", 32'(we_o), 32'd1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack_o"}, 32'(ack_o), 32'd0);
    check({tag, "_stb_o"}, 32'(stb_o), 32'd0);
    check({tag, "_cyc_o"}, 32'(cyc_o), 32'd0);
    check({tag, "_we_o"},  32'(we_o),  32'd0);
    check({tag, "_dat_o"}, 32'(dat_o), 32'd0);
`ifdef RX_DERAND_STATS_EN
    check({tag, "_byte_cnt_o"}, 32'(byte_cnt_o), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; dat_i = 8'h00; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; ack_i = 1'b1;
    m_r = SEED; m_new = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    fork monitor(); join_none
    @(posedge clk); #1;

    // Stray strobes: CYC_I low, then WE_I low, must not be accepted.
    stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h55;
    repeat (3) @(posedge clk); #1;
    check("cyc_low_ignored", 32'(stb_o), 32'd0);
    cyc_i = 1'b1; we_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("we_low_ignored", 32'(stb_o), 32'd0);
    check("we_low_cyc_o", 32'(cyc_o), 32'd0);
    end_burst();

    // T1: zero burst, first bytes hand-computed, then model.
    check("t1_stb_before", 32'(stb_o), 32'd0);
    send(8'h00, 1, 8'hBF);
    check("t1_latency_stb", 32'(stb_o), 32'd1);
    check("t1_cyc_o_busy", 32'(cyc_o), 32'd1);
    send(8'h00, 1, 8'h03);
    for (int i = 0; i < 6; i++) send(8'h00, 0, 8'h00);
    end_burst();
    wait_empty("t1_drain");
    repeat (2) @(negedge clk);
    check("t1_cyc_idle", 32'(cyc_o), 32'd0);
    @(posedge clk); #1;

    // T2: second burst reseeds.
    send(8'h00, 1, 8'hBF);
    send(8'h00, 1, 8'h03);
    send(8'hA5, 0, 8'h00);
    end_burst();
    wait_empty("t2_drain");

    // T3: downstream stall mid-burst.
    send(8'h12, 0, 8'h00);
    wait_empty("t3_pre_empty");
    ack_i = 1'b0;
    send(8'h34, 0, 8'h00);
    send(8'h56, 0, 8'h00);
    check("t3_ack_full", 32'(ack_o), 32'd0);
    stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h78;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t3_ack_stall", 32'(ack_o), 32'd0);
    end
    ack_i = 1'b1;
    send(8'h78, 0, 8'h00);
    send(8'h9A, 0, 8'h00);
    end_burst();
    wait_empty("t3_drain");

    // T4: model-randomized data must come back unchanged; stall across CYC_I fall.
    for (int i = 0; i < 62; i++) send(8'($urandom_range(0, 255)), 2, 8'h00);
    wait_empty("t4_mid_empty");
    ack_i = 1'b0;
    send(8'($urandom_range(0, 255)), 2, 8'h00);
    send(8'($urandom_range(0, 255)), 2, 8'h00);
    end_burst();
    repeat (3) @(negedge clk);
    check("t4_cyc_hold", 32'(cyc_o), 32'd1);
    check("t4_stb_hold", 32'(stb_o), 32'd1);
    @(posedge clk); #1;
    ack_i = 1'b1;
    begin
      bit fell;
      fell = 1'b0;
      for (int n = 0; n < 20 && !fell; n++) begin
        @(negedge clk);
        if (stb_o && !cyc_o) begin
          checks++; failures++;
          $display("FAIL t4_cyc_early got=cyc_o_0 exp=cyc_o_1");
        end
        if (!cyc_o) fell = 1'b1;
      end
      check("t4_cyc_fall", 32'(fell), 32'd1);
      check("t4_all_popped", 32'(exp_q.size()), 32'd0);
    end
    @(posedge clk); #1;

    // T5: async reset with two bytes buffered.
    ack_i = 1'b0;
    send(8'h11, 0, 8'h00);
    send(8'h22, 0, 8'h00);
    check("t5_buffered", 32'(stb_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    exp_q.delete();
    m_new = 1'b1;
    cyc_i = 1'b0;
    ack_i = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(8'h00, 1, 8'hBF);
    end_burst();
    wait_empty("t5_drain");

`ifdef RX_DERAND_STATS_EN
    // T6: delivered-byte counter.
    for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)), 0, 8'h00);
    end_burst();
    wait_empty("t6_drain");
    check("t6_cnt_40", 32'(byte_cnt_o), 32'd40);
    send(8'h00, 1, 8'hBF);
    check("t6_cnt_clear", 32'(byte_cnt_o), 32'd0);
    end_burst();
    wait_empty("t6_drain2");
    check("t6_cnt_1", 32'(byte_cnt_o), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
